// File: rtl/keypad_encoder.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce and a
// valid/ack holding register for the CPU side.
module keypad_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD} state_t;

    logic [3:0]        row_meta_q, row_sync_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [3:0]        col_out_q, col_out_d;
    logic [15:0]       frame_q, frame_d;
    state_t            state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              overrun_q, overrun_d;

    logic        slot_end, frame_end, accept;
    logic [15:0] frame_now;
    logic [1:0]  low_count;
    logic [3:0]  low_idx;
    logic        is_single;

    // Scan timing and frame accumulation; bit index of the frame is {row, col}.
    always_comb begin
        slot_end  = (slot_q == SLOT_LAST);
        frame_end = slot_end && (col_idx_q == 2'd3);
        slot_d    = slot_end ? '0 : slot_q + SLOT_W'(1);
        col_idx_d = slot_end ? col_idx_q + 2'd1 : col_idx_q;
        col_out_d = ~(4'b0001 << col_idx_d);

        frame_now = frame_q;
        for (int r = 0; r < 4; r++) begin
            frame_now[{2'(r), col_idx_q}] = row_sync_q[2'(r)];
        end
        frame_d = slot_end ? frame_now : frame_q;

        low_count = 2'd0;
        low_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!frame_now[4'(i)]) begin
                low_idx = 4'(i);
                if (low_count != 2'd2) low_count = low_count + 2'd1;
            end
        end
        is_single = (low_count == 2'd1);
    end

    // Debounce FSM, stepped only at frame end.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (is_single) begin
                        cand_d = low_idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_HELD;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (is_single && (low_idx == cand_q)) begin
                        if (cnt_q + CNT_W'(1) >= CNT_TARGET) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_HELD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (is_single) begin
                        cand_d = low_idx;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (low_count == 2'd0) begin
                        if (cnt_q + CNT_W'(1) >= CNT_TARGET) begin
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // CPU handshake: an ack on the accept edge frees the slot for the new key.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (key_ack && key_valid_q) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (accept) begin
            if (!key_valid_q || key_ack) begin
                key_code_d  = low_idx;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            slot_q      <= '0;
            col_idx_q   <= 2'd0;
            col_out_q   <= 4'b1110;
            frame_q     <= 16'hFFFF;
            state_q     <= S_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            row_meta_q  <= row_in;
            row_sync_q  <= row_meta_q;
            slot_q      <= slot_d;
            col_idx_q   <= col_idx_d;
            col_out_q   <= col_out_d;
            frame_q     <= frame_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: a keypad contact model drives row_in,
// accepted keys are checked against a queue of expected codes.
module tb_keypad_encoder;

    localparam int SD    = 4;
    localparam int DS    = 3;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        overrun;

    logic [15:0] pressed = 16'h0000;
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_valid = 1'b0;
    logic [3:0]  prev_code = 4'h0;

    keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Closed switch at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a new key is a rising key_valid or a code change while valid.
    always @(negedge clk) begin
        if (n_reset && key_valid && (!prev_valid || key_code != prev_code)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_key", 32'(key_code) | 32'h100, 32'h0);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                $display("key accepted: code=%h expected=%h overrun=%b", key_code, e, overrun);
                check("scoreboard_code", key_code, e);
            end
        end
        prev_valid <= key_valid;
        prev_code  <= key_code;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int i = 0;
        while (!key_valid && i < bound) begin
            @(negedge clk);
            i++;
        end
        check(tag, key_valid, 1);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic wait_frame_start();
        logic [3:0] last;
        int i = 0;
        last = col_out;
        @(negedge clk);
        while (!(col_out == 4'b1110 && last == 4'b0111) && i < 4 * FRAME) begin
            last = col_out;
            @(negedge clk);
            i++;
        end
        check("frame_align", (col_out == 4'b1110 && last == 4'b0111), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_col;

        // 1: reset values, then idle scanning
        repeat (3) @(negedge clk);
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_valid", key_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_key_code", key_code, 0);
        n_reset = 1'b1;
        for (int k = 0; k < 10 * FRAME; k++) begin
            exp_col = ~(4'b0001 << ((k / SD) % 4));
            check("idle_col_scan", col_out, exp_col);
            if (k % FRAME == 0) begin
                check("idle_valid", key_valid, 0);
                check("idle_overrun", overrun, 0);
            end
            @(negedge clk);
        end

        // 2: row2/col1 held
        pressed = 16'h0001 << 9;
        exp_q.push_back(4'h9);
        wait_valid("t2_valid", 6 * FRAME);
        check("t2_code", key_code, 4'h9);
        cycles(3 * FRAME);
        check("t2_still_valid", key_valid, 1);
        check("t2_no_overrun", overrun, 0);
        ack_pulse();
        check("t2_ack_drop", key_valid, 0);
        cycles(FRAME);
        check("t2_held_no_reaccept", key_valid, 0);
        pressed = 16'h0;
        cycles(5 * FRAME);

        // 3: bouncing row0/col3, then stable
        for (int t = 0; t < 11; t++) begin
            pressed[3] = ~pressed[3];
            cycles(6);
        end
        check("t3_bounce_no_valid", key_valid, 0);
        pressed = 16'h0008;
        exp_q.push_back(4'h3);
        wait_valid("t3_valid", 6 * FRAME);
        check("t3_code", key_code, 4'h3);
        ack_pulse();
        check("t3_ack_drop", key_valid, 0);
        pressed = 16'h0;
        cycles(5 * FRAME);

        // 4: two keys (MULTI) never accepted; remaining key accepted after release
        pressed = (16'h0001 << 4) | (16'h0001 << 14);
        cycles(5 * FRAME);
        check("t4_multi_no_valid", key_valid, 0);
        exp_q.push_back(4'h4);
        pressed = 16'h0001 << 4;
        wait_valid("t4_valid", 6 * FRAME);
        check("t4_code", key_code, 4'h4);
        ack_pulse();
        check("t4_ack_drop", key_valid, 0);
        pressed = 16'h0;
        cycles(5 * FRAME);

        // 5a: overrun keeps the oldest key
        pressed = 16'h0001 << 5;
        exp_q.push_back(4'h5);
        wait_valid("t5_valid", 6 * FRAME);
        pressed = 16'h0;
        cycles(5 * FRAME);
        pressed = 16'h0001 << 10;
        cycles(5 * FRAME);
        check("t5_code_kept", key_code, 4'h5);
        check("t5_valid_kept", key_valid, 1);
        check("t5_overrun_set", overrun, 1);
        ack_pulse();
        check("t5_ack_valid", key_valid, 0);
        check("t5_ack_overrun", overrun, 0);
        pressed = 16'h0;
        cycles(5 * FRAME);

        // 5b: ack on the exact accept edge takes the new key
        pressed = 16'h0001 << 5;
        exp_q.push_back(4'h5);
        wait_valid("t5b_valid", 6 * FRAME);
        pressed = 16'h0;
        cycles(5 * FRAME);
        wait_frame_start();
        pressed = 16'h0001 << 10;
        exp_q.push_back(4'hA);
        cycles(3 * FRAME - 1);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        check("t5b_code", key_code, 4'hA);
        check("t5b_valid", key_valid, 1);
        check("t5b_overrun", overrun, 0);
        ack_pulse();
        check("t5b_ack_drop", key_valid, 0);
        pressed = 16'h0;
        cycles(5 * FRAME);

        // 6: reset with a pending key and mid-CONFIRM
        pressed = 16'h0001 << 7;
        exp_q.push_back(4'h7);
        wait_valid("t6_valid", 6 * FRAME);
        pressed = 16'h0;
        cycles(5 * FRAME);
        pressed = 16'h0001 << 15;
        cycles(2 * FRAME + 1);
        #2;
        n_reset = 1'b0;
        #1;
        check("t6_rst_col_out", col_out, 4'b1110);
        check("t6_rst_valid", key_valid, 0);
        check("t6_rst_overrun", overrun, 0);
        check("t6_rst_code", key_code, 0);
        pressed = 16'h0;
        cycles(3);
        n_reset = 1'b1;
        for (int k = 0; k < 3 * SD; k++) begin
            exp_col = ~(4'b0001 << ((k / SD) % 4));
            check("t6_col_restart", col_out, exp_col);
            @(negedge clk);
        end
        cycles(5 * FRAME);
        check("t6_no_key_after_reset", key_valid, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
